// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: default addresses,
// FSM state encoding, redirect source priority encoding and PC step helper.
package fetch_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'hBFC0_0380;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } fetch_state_t;

  // Numeric order is the arbitration priority: larger value wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2,
    SRC_EX   = 2'd3
  } redir_src_t;

  // Sequential fetch step; wraps modulo 2^32, low bits pass through.
  function automatic logic [31:0] seq_pc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// In-order FIFO of issued fetch addresses. Occupancy doubles as the count of
// accepted-but-unanswered requests; the head is the PC of the next response.
module fetch_pc_fifo
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic        pop,
  output logic [31:0] head_addr,
  output logic [1:0]  count
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  logic [31:0] slot [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Address storage carries no reset; only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= push_addr;
  end

  assign head_addr = slot[rd_ptr];

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: issues sequential fetch addresses, arbitrates redirects,
// holds a redirect until the SRAM accepts it and drops stale responses.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ex,
  input  logic        mem_eret,
  input  logic [31:0] epc,
  input  logic        id_br_taken,
  input  logic [31:0] id_br_target,
  input  logic        id_stall,
  input  logic        if_stall,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid_in,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_pc,
  output logic        flush_pipe,
  output logic        pc_flush
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

  fetch_state_t state, state_next;
  redir_src_t   redir_src, pend_src;
  logic [31:0]  redir_target, pc, pend_addr;
  logic [1:0]   outst, outst_next, discard;
  logic         started, room, redir_acc, hs, pop, own_issue;

  fetch_pc_fifo #(.DEPTH(MAX_OUTST)) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hs),
    .push_addr (req_addr),
    .pop       (pop),
    .head_addr (rsp_pc),
    .count     (outst)
  );

  // Fixed-priority redirect arbitration: exception > eret > unstalled branch.
  always_comb begin
    redir_src    = SRC_NONE;
    redir_target = pc;
    if (mem_ex) begin
      redir_src    = SRC_EX;
      redir_target = EXC_VEC;
    end else if (mem_eret) begin
      redir_src    = SRC_ERET;
      redir_target = epc;
    end else if (id_br_taken && !id_stall) begin
      redir_src    = SRC_BR;
      redir_target = id_br_target;
    end
  end

  // A held redirect only yields to an equal or higher priority source.
  assign redir_acc = (redir_src != SRC_NONE) &&
                     ((state == ST_RUN) || (redir_src >= pend_src));
  assign room      = started && (outst < MAX_CNT);
  assign hs        = req_valid && req_ready;
  assign pop       = rsp_valid_in && (outst != 2'd0);
  assign own_issue = (state == ST_RUN) && redir_acc && hs;

  // Outstanding count after this cycle's handshake and response.
  always_comb begin
    outst_next = outst;
    case ({hs, pop})
      2'b10:   outst_next = outst + 2'd1;
      2'b01:   outst_next = outst - 2'd1;
      default: outst_next = outst;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next state: park in REDIR until the redirect target is accepted.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (redir_acc && !hs) state_next = ST_REDIR;
      ST_REDIR: if (redir_acc)        state_next = ST_REDIR;
                else if (hs)          state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Outputs: a redirect in RUN is offered directly, ignoring if_stall.
  always_comb begin
    req_valid = 1'b0;
    req_addr  = pc;
    case (state)
      ST_RUN: begin
        if (redir_acc) begin
          req_valid = room;
          req_addr  = redir_target;
        end else begin
          req_valid = room && !if_stall;
        end
      end
      ST_REDIR: begin
        req_valid = room;
        req_addr  = pend_addr;
      end
      default: ;
    endcase
    rsp_valid_out = rsp_valid_in && (discard == 2'd0);
    flush_pipe    = mem_ex || mem_eret;
    pc_flush      = redir_acc;
  end

  // Control state: PC, pending source, stale-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pend_src <= SRC_NONE;
      discard  <= 2'd0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redir_acc) begin
        // Everything accepted before the redirect is stale.
        discard <= own_issue ? outst_next - 2'd1 : outst_next;
        if (own_issue) pc <= seq_pc(redir_target);
        else           pend_src <= redir_src;
      end else begin
        if (rsp_valid_in && (discard != 2'd0)) discard <= discard - 2'd1;
        if (hs) pc <= seq_pc(req_addr);
      end
    end
  end

  // Pending redirect target; qualified by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (redir_acc && !own_issue) pend_addr <= redir_target;
  end

  // A response with nothing outstanding is an SRAM protocol error.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(rsp_valid_in && (outst == 2'd0)));
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: a queue scoreboard checks every
// request handshake and forwarded response; point checks cover flush pulses,
// reset state and gating.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ex, mem_eret, id_br_taken, id_stall, if_stall;
  logic [31:0] epc, id_br_target;
  logic        req_valid, req_ready, rsp_valid_in, rsp_valid_out;
  logic [31:0] req_addr, rsp_pc;
  logic        flush_pipe, pc_flush;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_req [$];
  logic [31:0] exp_rsp [$];
  logic [31:0] mon_e;
  bit          auto_rsp = 1'b0;

  fetch_redirect_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_ex        (mem_ex),
    .mem_eret      (mem_eret),
    .epc           (epc),
    .id_br_taken   (id_br_taken),
    .id_br_target  (id_br_target),
    .id_stall      (id_stall),
    .if_stall      (if_stall),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .rsp_valid_in  (rsp_valid_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_pc        (rsp_pc),
    .flush_pipe    (flush_pipe),
    .pc_flush      (pc_flush)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_both(input logic [31:0] a);
    exp_req.push_back(a);
    exp_rsp.push_back(a);
  endtask

  // One clock; the bench SRAM answers one cycle after a handshake when auto_rsp is set.
  task automatic cyc();
    logic hs_seen;
    @(negedge clk);
    hs_seen = req_valid && req_ready;
    @(posedge clk);
    #1;
    if (auto_rsp) rsp_valid_in = hs_seen;
  endtask

  // Monitor: every handshake and forwarded response must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req_valid && req_ready) begin
        n_vec++;
        if (exp_req.size() == 0) begin
          n_err++;
          $display("FAIL req_addr: got %h expected no request", req_addr);
        end else begin
          mon_e = exp_req.pop_front();
          if (req_addr !== mon_e) begin
            n_err++;
            $display("FAIL req_addr: got %h expected %h", req_addr, mon_e);
          end
        end
      end
      if (rsp_valid_out) begin
        n_vec++;
        if (exp_rsp.size() == 0) begin
          n_err++;
          $display("FAIL rsp_pc: got %h expected no response", rsp_pc);
        end else begin
          mon_e = exp_rsp.pop_front();
          if (rsp_pc !== mon_e) begin
            n_err++;
            $display("FAIL rsp_pc: got %h expected %h", rsp_pc, mon_e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mem_ex = 1'b0; mem_eret = 1'b0; epc = 32'h0;
    id_br_taken = 1'b0; id_br_target = 32'h0; id_stall = 1'b0; if_stall = 1'b0;
    req_ready = 1'b0; rsp_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1 ("rst_req_valid", req_valid, 1'b0);
    chk32("rst_pc", req_addr, 32'hBFC0_0000);
    chk1 ("rst_flush_pipe", flush_pipe, 1'b0);

    // Release: no request in the first cycle even with req_ready high.
    req_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk1("first_cycle_req_valid", req_valid, 1'b0);
    cyc();

    // 1: sequential fetch, one-cycle responses.
    auto_rsp = 1'b1;
    for (int i = 0; i < 6; i++) exp_both(32'hBFC0_0000 + 32'(4 * i));
    repeat (6) cyc();
    req_ready = 1'b0;
    cyc();
    auto_rsp = 1'b0;

    // 2: branch with two outstanding; both stale responses dropped.
    req_ready = 1'b1;
    exp_req.push_back(32'hBFC0_0018);
    exp_req.push_back(32'hBFC0_001C);
    cyc(); cyc();
    id_br_taken = 1'b1; id_br_target = 32'h8000_0100;
    #1;
    chk1("t2_pc_flush", pc_flush, 1'b1);
    chk1("t2_flush_pipe", flush_pipe, 1'b0);
    chk1("t2_full_req_valid", req_valid, 1'b0);
    cyc();
    id_br_taken = 1'b0; rsp_valid_in = 1'b1;
    #1;
    chk1("t2_drop1", rsp_valid_out, 1'b0);
    cyc();
    exp_req.push_back(32'h8000_0100);
    #1;
    chk1("t2_drop2", rsp_valid_out, 1'b0);
    cyc();
    exp_req.push_back(32'h8000_0104);
    exp_rsp.push_back(32'h8000_0100);
    cyc();
    req_ready = 1'b0;
    exp_rsp.push_back(32'h8000_0104);
    cyc();
    rsp_valid_in = 1'b0;

    // 3: exception beats a same-cycle branch; flushes last one cycle.
    req_ready = 1'b1; mem_ex = 1'b1;
    id_br_taken = 1'b1; id_br_target = 32'h8000_0200;
    exp_req.push_back(32'hBFC0_0380);
    #1;
    chk1 ("t3_flush_pipe", flush_pipe, 1'b1);
    chk1 ("t3_pc_flush", pc_flush, 1'b1);
    chk32("t3_req_addr", req_addr, 32'hBFC0_0380);
    cyc();
    mem_ex = 1'b0; id_br_taken = 1'b0; req_ready = 1'b0; rsp_valid_in = 1'b1;
    exp_rsp.push_back(32'hBFC0_0380);
    #1;
    chk1 ("t3_flush_pipe_end", flush_pipe, 1'b0);
    chk1 ("t3_pc_flush_end", pc_flush, 1'b0);
    chk32("t3_next_pc", req_addr, 32'hBFC0_0384);
    cyc();
    rsp_valid_in = 1'b0;

    // 4: branch held while SRAM not ready, then overwritten by eret.
    id_br_taken = 1'b1; id_br_target = 32'h8000_0300;
    #1;
    chk1("t4_br_accept", pc_flush, 1'b1);
    cyc();
    id_br_taken = 1'b0; if_stall = 1'b1;
    #1;
    chk1 ("t4_redir_valid", req_valid, 1'b1);
    chk32("t4_redir_addr", req_addr, 32'h8000_0300);
    cyc(); cyc();
    if_stall = 1'b0; mem_eret = 1'b1; epc = 32'h8000_2000;
    #1;
    chk1("t4_eret_flush_pipe", flush_pipe, 1'b1);
    chk1("t4_eret_pc_flush", pc_flush, 1'b1);
    cyc();
    mem_eret = 1'b0;
    id_br_taken = 1'b1; id_br_target = 32'h8000_0600;
    req_ready = 1'b1;
    exp_req.push_back(32'h8000_2000);
    #1;
    chk1 ("t4_low_prio_ignored", pc_flush, 1'b0);
    chk32("t4_eret_addr", req_addr, 32'h8000_2000);
    cyc();
    id_br_taken = 1'b0; req_ready = 1'b0; rsp_valid_in = 1'b1;
    exp_rsp.push_back(32'h8000_2000);
    cyc();
    rsp_valid_in = 1'b0;

    // 5: stalled branch is ignored; sequential fetch continues.
    auto_rsp = 1'b1; req_ready = 1'b1;
    id_stall = 1'b1; id_br_taken = 1'b1; id_br_target = 32'h8000_0400;
    #1;
    chk1("t5_no_redirect", pc_flush, 1'b0);
    for (int i = 0; i < 3; i++) exp_both(32'h8000_2004 + 32'(4 * i));
    repeat (3) cyc();
    id_br_taken = 1'b0; id_stall = 1'b0; req_ready = 1'b0;
    cyc();
    if_stall = 1'b1; req_ready = 1'b1;
    #1;
    chk1("if_stall_blocks", req_valid, 1'b0);
    if_stall = 1'b0; req_ready = 1'b0;

    // PC wrap at the top of the address space.
    id_br_taken = 1'b1; id_br_target = 32'hFFFF_FFFC; req_ready = 1'b1;
    exp_both(32'hFFFF_FFFC);
    cyc();
    id_br_taken = 1'b0;
    exp_both(32'h0000_0000);
    cyc();
    req_ready = 1'b0;
    cyc();
    auto_rsp = 1'b0;

    // 6: async reset while a redirect is held with two outstanding.
    req_ready = 1'b1;
    exp_req.push_back(32'h0000_0004);
    exp_req.push_back(32'h0000_0008);
    cyc(); cyc();
    id_br_taken = 1'b1; id_br_target = 32'h8000_0500;
    #1;
    chk1("t6_pc_flush", pc_flush, 1'b1);
    cyc();
    id_br_taken = 1'b0; req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1 ("t6_rst_req_valid", req_valid, 1'b0);
    chk32("t6_rst_pc", req_addr, 32'hBFC0_0000);
    rsp_valid_in = 1'b1;
    #1;
    chk1("t6_rst_discard_clear", rsp_valid_out, 1'b1);
    rsp_valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; req_ready = 1'b1;
    #1;
    chk1("t6_first_cycle_req_valid", req_valid, 1'b0);
    cyc();
    auto_rsp = 1'b1;
    exp_both(32'hBFC0_0000);
    exp_both(32'hBFC0_0004);
    cyc(); cyc();
    req_ready = 1'b0;
    cyc();
    auto_rsp = 1'b0;

    chk32("req_queue_drained", 32'(exp_req.size()), 32'd0);
    chk32("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
